// File: rtl/alu_arb_if.sv
// alu_arb_if: request, ALU-side and response signals of the shared-ALU arbiter.
// slave  - seen by the arbiter (alu_arb)
// master - seen by the requesters / ALU / response consumer
interface alu_arb_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [2:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [2:0] req1_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_zero;
  logic       alu_of;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_data;
  logic [2:0] rsp_flags;
  logic [7:0] gnt_cnt0;
  logic [7:0] gnt_cnt1;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_out, alu_zero, alu_of, alu_carry,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_data, rsp_flags,
    output gnt_cnt0, gnt_cnt1
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_out, alu_zero, alu_of, alu_carry,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags,
    input  gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter/sequencer for the shared 4-bit ALU.
// IDLE -> EXEC -> RESP; operands registered toward the ALU, result and flags
// captured one cycle later and held until the response handshake.
// Optional macro ALU_ARB_STATS_EN enables saturating per-port grant counters;
// when undefined the counters are tied to zero.
module alu_arb (
  input logic       clk,
  input logic       rst,
  alu_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q;
  logic       last_grant_q;
  logic       id_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [2:0] alu_sel_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [3:0] rsp_data_q;
  logic [2:0] rsp_flags_q;

  logic gnt0;
  logic gnt1;
  logic acc0;
  logic acc1;

  // Grant: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    acc0 = (state_q == IDLE) & gnt0;
    acc1 = (state_q == IDLE) & gnt1;
  end

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;

  // Sequencer FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc0 | acc1) begin
            alu_a_q      <= acc1 ? bus.req1_a  : bus.req0_a;
            alu_b_q      <= acc1 ? bus.req1_b  : bus.req0_b;
            alu_sel_q    <= acc1 ? bus.req1_op : bus.req0_op;
            id_q         <= acc1;
            last_grant_q <= acc1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= bus.alu_out;
          rsp_flags_q <= {bus.alu_carry, bus.alu_of, bus.alu_zero};
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] gnt_cnt0_q;
  logic [7:0] gnt_cnt0_d;
  logic [7:0] gnt_cnt1_q;
  logic [7:0] gnt_cnt1_d;

  // Saturating per-port accept counters.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (acc0 && gnt_cnt0_q != 8'hFF) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
    if (acc1 && gnt_cnt1_q != 8'hFF) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign bus.gnt_cnt0 = gnt_cnt0_q;
  assign bus.gnt_cnt1 = gnt_cnt1_q;
`else
  assign bus.gnt_cnt0 = '0;
  assign bus.gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed bench for alu_arb with a small behavioural ALU.
module tb_alu_arb;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_arb_if bus ();

  alu_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 000 add, 001 sub, 010 and, 011 or, 100 xor, others pass A.
  logic [4:0] sum5;
  always_comb begin
    sum5          = '0;
    bus.alu_out   = bus.alu_a;
    bus.alu_carry = 1'b0;
    bus.alu_of    = 1'b0;
    case (bus.alu_sel)
      3'b000: begin
        sum5          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_out   = sum5[3:0];
        bus.alu_carry = sum5[4];
        bus.alu_of    = (bus.alu_a[3] == bus.alu_b[3]) && (sum5[3] != bus.alu_a[3]);
      end
      3'b001: begin
        bus.alu_out   = bus.alu_a - bus.alu_b;
        bus.alu_carry = bus.alu_a < bus.alu_b;
      end
      3'b010: bus.alu_out = bus.alu_a & bus.alu_b;
      3'b011: bus.alu_out = bus.alu_a | bus.alu_b;
      3'b100: bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = bus.alu_a;
    endcase
    bus.alu_zero = (bus.alu_out == 4'h0);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp_ready  = 1'b0;

    // Reset state
    #1;
    chk("rst_rsp_valid", 8'(bus.rsp_valid), 8'h00);
    chk("rst_alu_a",     8'(bus.alu_a),     8'h00);
    chk("rst_rsp_data",  8'(bus.rsp_data),  8'h00);
    chk("rst_rsp_flags", 8'(bus.rsp_flags), 8'h00);
    chk("rst_ready0",    8'(bus.req0_ready), 8'h00);
    chk("rst_cnt0",      bus.gnt_cnt0,      8'h00);
    chk("rst_cnt1",      bus.gnt_cnt1,      8'h00);
    tick();
    tick();
    rst = 1'b0;

    // Single op on port 0: 3 + 5 = 8, signed overflow
    bus.req0_valid = 1'b1; bus.req0_a = 4'h3; bus.req0_b = 4'h5; bus.req0_op = 3'b000;
    bus.rsp_ready  = 1'b1;
    #1;
    chk("idle_ready0", 8'(bus.req0_ready), 8'h01);
    chk("idle_ready1", 8'(bus.req1_ready), 8'h00);
    tick();
    bus.req0_valid = 1'b0;
    chk("op1_alu_a",     8'(bus.alu_a),     8'h03);
    chk("op1_alu_b",     8'(bus.alu_b),     8'h05);
    chk("op1_alu_sel",   8'(bus.alu_sel),   8'h00);
    chk("op1_exec_rspv", 8'(bus.rsp_valid), 8'h00);
    tick();
    chk("op1_rsp_valid", 8'(bus.rsp_valid), 8'h01);
    chk("op1_rsp_id",    8'(bus.rsp_id),    8'h00);
    chk("op1_rsp_data",  8'(bus.rsp_data),  8'h08);
    chk("op1_rsp_flags", 8'(bus.rsp_flags), 8'h02);
    tick();
    chk("op1_rsp_done",  8'(bus.rsp_valid), 8'h00);
    chk("op1_alu_hold",  8'(bus.alu_a),     8'h03);

    // Backpressure: port 1 op F + 1 -> 0 with carry and zero
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 4'hF; bus.req1_b = 4'h1; bus.req1_op = 3'b000;
    #1;
    chk("bp_ready1", 8'(bus.req1_ready), 8'h01);
    tick();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 4'h2; bus.req0_b = 4'h2; bus.req0_op = 3'b010;
    #1;
    chk("bp_exec_ready0", 8'(bus.req0_ready), 8'h00);
    tick();
    chk("bp_rsp_valid", 8'(bus.rsp_valid), 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid",  8'(bus.rsp_valid),  8'h01);
      chk("bp_hold_id",     8'(bus.rsp_id),     8'h01);
      chk("bp_hold_data",   8'(bus.rsp_data),   8'h00);
      chk("bp_hold_flags",  8'(bus.rsp_flags),  8'h05);
      chk("bp_hold_ready0", 8'(bus.req0_ready), 8'h00);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_hs_valid",  8'(bus.rsp_valid),  8'h00);
    chk("bp_hs_ready0", 8'(bus.req0_ready), 8'h01);
    tick();
    bus.req0_valid = 1'b0;
    chk("bp_next_alu_a",   8'(bus.alu_a),   8'h02);
    chk("bp_next_alu_sel", 8'(bus.alu_sel), 8'h02);
    tick();
    chk("bp_next_valid", 8'(bus.rsp_valid), 8'h01);
    chk("bp_next_id",    8'(bus.rsp_id),    8'h00);
    chk("bp_next_data",  8'(bus.rsp_data),  8'h02);
    tick();
    chk("bp_next_done",  8'(bus.rsp_valid), 8'h00);

    // Reset in EXEC after a port-0 grant (last_grant would otherwise be 0)
    bus.req0_valid = 1'b1; bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.req0_op = 3'b000;
    tick();
    bus.req0_valid = 1'b0;
    chk("ro_alu_a", 8'(bus.alu_a), 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("ro_rsp_valid", 8'(bus.rsp_valid), 8'h00);
    chk("ro_alu_a_clr", 8'(bus.alu_a),     8'h00);
    tick();
    chk("ro_rsp_valid2", 8'(bus.rsp_valid), 8'h00);
    rst = 1'b0;

    // Contention: port 0 does 1+2=3, port 1 does 7-7=0 (zero)
    bus.req0_valid = 1'b1; bus.req0_a = 4'h1; bus.req0_b = 4'h2; bus.req0_op = 3'b000;
    bus.req1_valid = 1'b1; bus.req1_a = 4'h7; bus.req1_b = 4'h7; bus.req1_op = 3'b001;
    #1;
    chk("tie_ready0", 8'(bus.req0_ready), 8'h01);
    chk("tie_ready1", 8'(bus.req1_ready), 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_alu_a",   8'(bus.alu_a),      (k % 2 == 1) ? 8'h07 : 8'h01);
      chk("rr_ready0",  8'(bus.req0_ready), 8'h00);
      chk("rr_ready1",  8'(bus.req1_ready), 8'h00);
      tick();
      chk("rr_valid",   8'(bus.rsp_valid),  8'h01);
      chk("rr_id",      8'(bus.rsp_id),     8'(k % 2));
      chk("rr_data",    8'(bus.rsp_data),   (k % 2 == 1) ? 8'h00 : 8'h03);
      chk("rr_flags",   8'(bus.rsp_flags),  (k % 2 == 1) ? 8'h01 : 8'h00);
      tick();
      chk("rr_done",    8'(bus.rsp_valid),  8'h00);
      chk("rr_next_r0", 8'(bus.req0_ready), (k % 2 == 1) ? 8'h01 : 8'h00);
      chk("rr_next_r1", 8'(bus.req1_ready), (k % 2 == 1) ? 8'h00 : 8'h01);
    end

    // Grant counters: 300 port-1 grants from a clean reset
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("st_cnt0_clr", bus.gnt_cnt0, 8'h00);
    chk("st_cnt1_clr", bus.gnt_cnt1, 8'h00);
    bus.req1_valid = 1'b1;
    repeat (30) tick();
`ifdef ALU_ARB_STATS_EN
    chk("st_cnt1_10", bus.gnt_cnt1, 8'd10);
`else
    chk("st_cnt1_10", bus.gnt_cnt1, 8'd0);
`endif
    repeat (870) tick();
    bus.req1_valid = 1'b0;
    tick();
`ifdef ALU_ARB_STATS_EN
    chk("st_cnt1_sat", bus.gnt_cnt1, 8'hFF);
`else
    chk("st_cnt1_sat", bus.gnt_cnt1, 8'h00);
`endif
    chk("st_cnt0", bus.gnt_cnt0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arb.md
# alu_arb

Two-port arbiter and sequencer for the shared 4-bit ALU on the board top level. Two requesters (switch panel, UART command decoder) submit one ALU operation each through a valid/ready handshake. The block grants them round-robin, drives the ALU operand/select inputs from registers, and captures the combinational result plus zero/overflow/carry flags. It returns the result on a response channel tagged with the requester ID, feeding the seg/LED display path.

## Interface
- No parameters; operand width 4, select width 3, fixed to the ALU.
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req0_valid, req1_valid  in  1  request present (port 0 / port 1)
- req0_ready, req1_ready  out  1  request accepted this cycle when valid&ready
- req0_a, req1_a  in  4  operand A
- req0_b, req1_b  in  4  operand B
- req0_op, req1_op  in  3  ALU select, passed through unmodified
- alu_a, alu_b  out  4  registered operands to ALU data_a/data_b
- alu_sel  out  3  registered select to ALU sel
- alu_out  in  4  ALU result (combinational from alu_a/b/sel)
- alu_zero, alu_of, alu_carry  in  1  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the op (0/1)
- rsp_data  out  4  captured alu_out
- rsp_flags  out  3  captured {alu_carry, alu_of, alu_zero}
- gnt_cnt0, gnt_cnt1  out  8  grant counters (see Configuration)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant logic is combinational over req*_valid.
  - Only one valid: that port is granted.
  - Both valid: the port not granted last wins; last_grant resets to 1, so port 0 wins the first tie.
  - reqN_ready = 1 only for the granted port, only in IDLE. Both readies are 0 in EXEC/RESP.
  - On accept: latch a/b/op into alu_a/alu_b/alu_sel, latch ID, update last_grant, go to EXEC.
- EXEC (one cycle): ALU settles on registered inputs. At the clock edge, capture alu_out and flags into rsp_data/rsp_flags, set rsp_valid, go to RESP.
- RESP: hold rsp_valid and all rsp_* stable until rsp_valid&rsp_ready, then clear rsp_valid and go to IDLE.
  - alu_a/b/sel keep their last values until the next accept.
- A requester must hold valid and payload stable until ready. The block does not check this.
- The block never inspects op; all select encodings are legal.

## Timing
- Accept at edge T → alu_* valid from T+1 → rsp_valid high from T+2.
- Minimum initiation interval is 3 cycles (accept, exec, response handshake). A new accept is possible in the cycle after the response handshake.
- rsp_ready held high: response lasts exactly one cycle.
- rsp_ready low: response is held indefinitely and no new grant is issued.
- Reset value of every output is 0, except readies, which follow IDLE grant logic combinationally.
  - State IDLE, last_grant=1, gnt_cnt0/1=0.
- Reset asserted in EXEC or RESP aborts the op. The pending response is discarded and rsp_valid drops asynchronously.

## Configuration
- ALU_ARB_STATS_EN defined: gnt_cnt0/gnt_cnt1 each increment by 1 on every accept from that port.
  - They saturate at 8'hFF and are cleared only by rst.
- Not defined: counter logic is absent and gnt_cnt0/gnt_cnt1 are tied to 8'h00.

## Test plan
- Reset then idle: all outputs 0; req0_valid=1 alone → req0_ready=1 in the same cycle.
- Single op, port 0: a=4'h3, b=4'h5, op=3'b000.
  - At T+1: alu_a=3, alu_b=5, alu_sel=0.
  - Bench ALU model drives alu_out=4'h8, zero=0, of=1, carry=0.
  - At T+2: rsp_valid=1, rsp_id=0, rsp_data=8, rsp_flags=3'b010.
- Contention: both ports valid continuously, rsp_ready=1 → grant order 0,1,0,1; each rsp_id matches; one response every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_* stay stable, req readies stay 0.
  - After rsp_ready=1: one handshake, then the next grant in the following cycle.
- Reset mid-op: assert rst in EXEC → rsp_valid stays 0, state IDLE; the next tie grants port 0.
- With ALU_ARB_STATS_EN: 300 port-1 grants → gnt_cnt1=8'hFF, gnt_cnt0=0. Without the macro, both stay 8'h00.
